// File: rtl/axis_credit_dest_tagger.sv
// Per-packet destination tagger for an MSB-routed AXI-stream switch: round-robin
// over enabled ports holding credit, with one credit counter per output port.

module axis_credit_dest_tagger_ctr #(
   parameter int CW         = 4,
   parameter int SLOT_COUNT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_dec,
   input  logic          i_ret,
   output logic [CW-1:0] o_count,
   output logic          o_sat
);
   logic [CW-1:0] r_cnt;

   // A return landing on a full counter with no same-cycle consume is lost.
   assign o_sat   = i_ret && !i_dec && (r_cnt == CW'(SLOT_COUNT));
   assign o_count = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= CW'(SLOT_COUNT);
      else if (i_dec && !i_ret)
         r_cnt <= r_cnt - 1'b1;
      else if (i_ret && !i_dec && (r_cnt != CW'(SLOT_COUNT)))
         r_cnt <= r_cnt + 1'b1;
   end
endmodule

module axis_credit_dest_tagger #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int USER_WIDTH = 1,
   parameter int M_COUNT    = 4,
   parameter int CL_M_COUNT = $clog2(M_COUNT),
   parameter int DEST_WIDTH = CL_M_COUNT+4,
   parameter int SLOT_COUNT = 8,
   parameter int CW         = $clog2(SLOT_COUNT+1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   input  logic [DEST_WIDTH-CL_M_COUNT-1:0] s_axis_tdest,
   input  logic [USER_WIDTH-1:0]          s_axis_tuser,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [DEST_WIDTH-1:0]          m_axis_tdest,
   output logic [USER_WIDTH-1:0]          m_axis_tuser,
   input  logic [M_COUNT-1:0]             dest_enable,
   input  logic                           credit_ret_valid,
   input  logic [CL_M_COUNT-1:0]          credit_ret_dest,
   output logic [M_COUNT*CW-1:0]          credit_count,
   output logic                           credit_overflow
);
   typedef enum logic {IDLE = 1'b0, PROC = 1'b1} state_t;

   state_t                      r_state, w_state_nxt;
   logic [CL_M_COUNT-1:0]       r_ptr, r_sel, w_pick, w_port;
   logic [M_COUNT-1:0]          w_elig, w_dec, w_ret, w_sat;
   logic [M_COUNT-1:0][CW-1:0]  w_count;
   logic                        w_found, w_load, w_tready, w_hs, w_first, w_bad_ret;
   int                          w_idx;

   logic [DATA_WIDTH-1:0]       r_tdata;
   logic [KEEP_WIDTH-1:0]       r_tkeep;
   logic [USER_WIDTH-1:0]       r_tuser;
   logic [DEST_WIDTH-1:0]       r_tdest;
   logic                        r_tvalid, r_tlast, r_ovf;

   genvar n;
   generate
      for (n = 0; n < M_COUNT; n++) begin : g_ctr
         assign w_dec[n]  = w_first && (w_pick == CL_M_COUNT'(n));
         assign w_ret[n]  = credit_ret_valid && (credit_ret_dest == CL_M_COUNT'(n));
         // Pre-update credit: a return becomes usable the following cycle.
         assign w_elig[n] = dest_enable[n] && (w_count[n] != '0);

         axis_credit_dest_tagger_ctr #(.CW(CW), .SLOT_COUNT(SLOT_COUNT)) u_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_dec   (w_dec[n]),
            .i_ret   (w_ret[n]),
            .o_count (w_count[n]),
            .o_sat   (w_sat[n])
         );
      end
   endgenerate

   // First eligible port strictly after the pointer, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int k = 1; k <= M_COUNT; k++) begin
         w_idx = (int'(r_ptr) + k) % M_COUNT;
         for (int m = 0; m < M_COUNT; m++) begin
            if (!w_found && (m == w_idx) && w_elig[m]) begin
               w_found = 1'b1;
               w_pick  = CL_M_COUNT'(m);
            end
         end
      end
   end

   assign w_load    = !r_tvalid || m_axis_tready;
   assign w_tready  = rst_n && w_load && ((r_state == PROC) || w_found);
   assign w_hs      = s_axis_tvalid && w_tready;
   assign w_first   = w_hs && (r_state == IDLE);
   assign w_port    = (r_state == IDLE) ? w_pick : r_sel;
   assign w_bad_ret = credit_ret_valid && !(|w_ret);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_hs && !s_axis_tlast) w_state_nxt = PROC;
         PROC:    if (w_hs && s_axis_tlast)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_ptr    <= CL_M_COUNT'(M_COUNT-1);
         r_sel    <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tuser  <= '0;
         r_tdest  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ovf   <= w_bad_ret || (|w_sat);
         if (w_first) begin
            r_ptr <= w_pick;
            r_sel <= w_pick;
         end
         if (w_load) begin
            r_tvalid <= w_hs;
            if (w_hs) begin
               r_tdata <= s_axis_tdata;
               r_tkeep <= s_axis_tkeep;
               r_tlast <= s_axis_tlast;
               r_tuser <= s_axis_tuser;
               r_tdest <= {w_port, s_axis_tdest};
            end
         end
      end
   end

   assign s_axis_tready   = w_tready;
   assign m_axis_tvalid   = r_tvalid;
   assign m_axis_tdata    = r_tdata;
   assign m_axis_tkeep    = r_tkeep;
   assign m_axis_tlast    = r_tlast;
   assign m_axis_tuser    = r_tuser;
   assign m_axis_tdest    = r_tdest;
   assign credit_count    = w_count;
   assign credit_overflow = r_ovf;
endmodule

// File: tb/tb_axis_credit_dest_tagger.sv
// Directed + randomized bench for axis_credit_dest_tagger with a beat scoreboard.

module tb_axis_credit_dest_tagger;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tvalid, s_tready, s_tlast;
   logic [3:0]  s_tdest;
   logic        s_tuser;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tvalid, m_tready, m_tlast;
   logic [5:0]  m_tdest;
   logic        m_tuser;
   logic [3:0]  den;
   logic        ret_v;
   logic [1:0]  ret_d;
   logic [15:0] ccnt;
   logic        covf;

   // Second instance with a non-power-of-two port count to reach out-of-range returns.
   logic [63:0] t3_tdata;
   logic [7:0]  t3_tkeep;
   logic        t3_tvalid, t3_tready, t3_tlast;
   logic [5:0]  t3_tdest;
   logic        t3_tuser;
   logic        r3_v;
   logic [1:0]  r3_d;
   logic [11:0] c3_cnt;
   logic        c3_ovf;

   always #5 clk = ~clk;

   axis_credit_dest_tagger u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
      .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tdest(m_tdest),
      .m_axis_tuser(m_tuser),
      .dest_enable(den), .credit_ret_valid(ret_v), .credit_ret_dest(ret_d),
      .credit_count(ccnt), .credit_overflow(covf)
   );

   axis_credit_dest_tagger #(.M_COUNT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(64'd0), .s_axis_tkeep(8'd0), .s_axis_tvalid(1'b0),
      .s_axis_tready(t3_tready), .s_axis_tlast(1'b0), .s_axis_tdest(4'd0),
      .s_axis_tuser(1'b0),
      .m_axis_tdata(t3_tdata), .m_axis_tkeep(t3_tkeep), .m_axis_tvalid(t3_tvalid),
      .m_axis_tready(1'b1), .m_axis_tlast(t3_tlast), .m_axis_tdest(t3_tdest),
      .m_axis_tuser(t3_tuser),
      .dest_enable(3'b111), .credit_ret_valid(r3_v), .credit_ret_dest(r3_d),
      .credit_count(c3_cnt), .credit_overflow(c3_ovf)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic [5:0]  dest;
   } beat_t;

   beat_t      q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         n_in  = 0;
   int         n_out = 0;
   logic [1:0] exp_port;
   logic       s_hs;
   logic       rand_mode = 1'b0;
   int         w;
   int         sum0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int csum(input logic [15:0] c);
      return int'(c[3:0]) + int'(c[7:4]) + int'(c[11:8]) + int'(c[15:12]);
   endfunction

   // One clock: sample at negedge (scoreboard pop, then push), return at posedge+1.
   task automatic step();
      beat_t e;
      @(negedge clk);
      s_hs = s_tvalid && s_tready;
      if (rand_mode && s_tvalid && m_tready)
         chk("no_bubble", {63'd0, s_tready}, 64'd1);
      if (m_tvalid && m_tready) begin
         n_out++;
         if (q.size() == 0) begin
            chk("spurious_beat", {63'd0, m_tvalid}, 64'd0);
         end else begin
            e = q.pop_front();
            chk("beat_data", m_tdata, e.data);
            chk("beat_meta", {48'd0, m_tkeep, m_tlast, m_tuser, m_tdest},
                {48'd0, e.keep, e.last, e.user, e.dest});
         end
      end
      if (s_hs) begin
         n_in++;
         q.push_back('{data: s_tdata, keep: s_tkeep, last: s_tlast, user: s_tuser,
                       dest: {exp_port, s_tdest}});
      end
      @(posedge clk);
      #1;
      if (rand_mode) m_tready = ($urandom_range(0, 99) < 30);
   endtask

   task automatic send_beat(input logic last, output int waits);
      s_tvalid = 1'b1;
      s_tdata  = {$urandom, $urandom};
      s_tkeep  = 8'($urandom);
      s_tuser  = 1'($urandom);
      s_tdest  = 4'($urandom);
      s_tlast  = last;
      waits    = 0;
      do begin
         step();
         waits++;
      end while (!s_hs && waits < 50);
      if (!s_hs) chk("handshake_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
      s_tdest = '0; s_tuser = 1'b0; m_tready = 1'b1; den = 4'hF;
      ret_v = 1'b0; ret_d = '0; r3_v = 1'b0; r3_d = '0; exp_port = '0; s_hs = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("rst_tdata", m_tdata, 64'd0);
      chk("rst_credits", {48'd0, ccnt}, 64'h8888);
      chk("rst_ovf", {63'd0, covf}, 64'd0);
      chk("rst_tready", {63'd0, s_tready}, 64'd0);
      rst_n = 1'b1;
      step();

      // Four single-beat packets land on ports 0..3 with no stall.
      for (int p = 0; p < 4; p++) begin
         exp_port = 2'(p);
         send_beat(1'b1, w);
         chk("b2b_wait", 64'(w), 64'd1);
         if (p == 0) chk("first_latency", {63'd0, m_tvalid}, 64'd1);
      end
      s_tvalid = 1'b0;
      repeat (2) step();
      chk("credits_after4", {48'd0, ccnt}, 64'h7777);

      // Mid-packet disable of the selected port must not move the packet.
      exp_port = 2'd0;
      send_beat(1'b0, w);
      den = 4'b1110;
      send_beat(1'b0, w);
      send_beat(1'b1, w);
      s_tvalid = 1'b0;
      den = 4'hF;
      repeat (2) step();
      chk("credits_3beat", {48'd0, ccnt}, 64'h7776);

      // Drain port 1, park pointer on 0, then skip the empty port 1.
      den = 4'b0010; exp_port = 2'd1;
      repeat (7) send_beat(1'b1, w);
      den = 4'b0001; exp_port = 2'd0;
      send_beat(1'b1, w);
      den = 4'b0111; exp_port = 2'd2;
      send_beat(1'b1, w);
      s_tvalid = 1'b0;
      repeat (2) step();
      chk("credits_skip", {48'd0, ccnt}, 64'h7605);

      // Empty every counter, then verify stall and next-cycle use of a return.
      den = 4'b0001; exp_port = 2'd0; repeat (5) send_beat(1'b1, w);
      den = 4'b0100; exp_port = 2'd2; repeat (6) send_beat(1'b1, w);
      den = 4'b1000; exp_port = 2'd3; repeat (7) send_beat(1'b1, w);
      den = 4'hF;
      repeat (3) begin
         step();
         chk("nocredit_stall", {63'd0, s_hs}, 64'd0);
      end
      chk("credits_empty", {48'd0, ccnt}, 64'h0000);
      ret_v = 1'b1; ret_d = 2'd3;
      step();
      chk("ret_cycle_stall", {63'd0, s_hs}, 64'd0);
      ret_v = 1'b0;
      exp_port = 2'd3;
      send_beat(1'b1, w);
      chk("ret_next_cycle", 64'(w), 64'd1);
      s_tvalid = 1'b0;

      // Refill port 2 to 5, then consume and return on it in one cycle.
      ret_v = 1'b1; ret_d = 2'd2;
      repeat (5) step();
      ret_v = 1'b0;
      step();
      chk("credits_refill", {48'd0, ccnt}, 64'h0500);
      exp_port = 2'd2; ret_v = 1'b1; ret_d = 2'd2;
      send_beat(1'b1, w);
      ret_v = 1'b0; s_tvalid = 1'b0;
      chk("same_cycle_ovf", {63'd0, covf}, 64'd0);
      chk("same_cycle_cnt", {48'd0, ccnt}, 64'h0500);
      step();

      // Reset in the middle of a packet drops it and restores credits.
      exp_port = 2'd2;
      send_beat(1'b0, w);
      rst_n = 1'b0; s_tvalid = 1'b0;
      q.delete();
      #1;
      chk("midrst_tvalid", {63'd0, m_tvalid}, 64'd0);
      chk("midrst_credits", {48'd0, ccnt}, 64'h8888);
      chk("midrst_tready", {63'd0, s_tready}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      exp_port = 2'd0;
      send_beat(1'b1, w);
      s_tvalid = 1'b0;
      step();
      chk("post_rst_credits", {48'd0, ccnt}, 64'h8887);

      // Saturating return pulses overflow for exactly one cycle.
      ret_v = 1'b1; ret_d = 2'd1;
      step();
      ret_v = 1'b0;
      chk("sat_ovf_pulse", {63'd0, covf}, 64'd1);
      chk("sat_cnt", {48'd0, ccnt}, 64'h8887);
      step();
      chk("sat_ovf_clear", {63'd0, covf}, 64'd0);

      // Out-of-range return on the three-port instance.
      r3_v = 1'b1; r3_d = 2'd3;
      step();
      r3_v = 1'b0;
      chk("badret_ovf", {63'd0, c3_ovf}, 64'd1);
      chk("badret_cnt", {52'd0, c3_cnt}, 64'h888);
      step();
      chk("badret_clear", {63'd0, c3_ovf}, 64'd0);

      // Randomized backpressure over 20 packets of 1..6 beats.
      sum0 = csum(ccnt);
      n_in = 0; n_out = 0;
      rand_mode = 1'b1;
      for (int p = 0; p < 20; p++) begin
         int len;
         len = $urandom_range(1, 6);
         exp_port = 2'((p + 1) % 4);
         for (int b = 0; b < len; b++) send_beat(b == len - 1, w);
      end
      s_tvalid = 1'b0;
      rand_mode = 1'b0;
      m_tready = 1'b1;
      repeat (4) step();
      chk("rand_drained", 64'(q.size()), 64'd0);
      chk("rand_beats", 64'(n_out), 64'(n_in));
      chk("rand_credits", 64'(sum0 - csum(ccnt)), 64'd20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axis_credit_dest_tagger.md
Name: axis_credit_dest_tagger

Overview:
- Packet-level destination selector placed directly upstream of the MSB-routed AXI-stream switch.
- Picks an output port per packet by round-robin over enabled ports that hold credit. Writes the port index into the tdest MSBs and holds it for the whole packet.
- Keeps one credit counter per port. A credit is consumed on each packet's first beat and returned by the downstream consumer (one credit = one packet slot).

Parameters:
- DATA_WIDTH, 64: tdata width.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- USER_WIDTH, 1: tuser width, passed through.
- M_COUNT, 4: number of switch outputs to balance across; must be ≥2.
- CL_M_COUNT, $clog2(M_COUNT): port index width.
- DEST_WIDTH, CL_M_COUNT+4: output tdest width; the MSB CL_M_COUNT bits are the port, the LSBs are passed through from input.
- SLOT_COUNT, 8: credits per port after reset, and the saturation ceiling.
- CW, $clog2(SLOT_COUNT+1): credit counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tdest  in  DEST_WIDTH-CL_M_COUNT  LSB tdest bits, passed through.
- s_axis_tuser  in  USER_WIDTH  input user sideband.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tdest  out  DEST_WIDTH  {selected port, input LSBs}.
- m_axis_tuser  out  USER_WIDTH  output user sideband.
- dest_enable  in  M_COUNT  per-port eligibility mask, sampled only at packet start.
- credit_ret_valid  in  1  credit return strobe, one credit per cycle.
- credit_ret_dest  in  CL_M_COUNT  port receiving the returned credit.
- credit_count  out  M_COUNT*CW  current credits, port n at [n*CW +: CW].
- credit_overflow  out  1  one-cycle pulse when a return hits a full counter.

Behaviour:
- Reset (rst_n low, async):
  - FSM=IDLE, RR pointer=M_COUNT-1 (so port 0 wins first), every credit=SLOT_COUNT.
  - m_axis_tvalid=0, m_axis_* data=0, credit_overflow=0, s_axis_tready=0.
- Reset mid-packet: the packet is dropped and credits are restored to SLOT_COUNT. Upstream must restart on a packet boundary.
- Output stage is a single register stage with 1-cycle latency.
  - Register load condition is load = !m_axis_tvalid || m_axis_tready.
  - Beats are never dropped or duplicated; tdata, tkeep, tlast and tuser are unmodified.
- FSM has two states, IDLE (awaiting first beat) and PROC (mid-packet).
  - IDLE:
    - eligible[n] = dest_enable[n] && credit[n]!=0.
    - s_axis_tready = load && |eligible.
    - Selection: first eligible port strictly after the RR pointer, wrapping at M_COUNT-1→0.
    - On a first-beat handshake: latch sel, RR pointer<=sel, credit[sel] decrements.
    - If !tlast, go to PROC; if tlast (single-beat packet), stay IDLE.
    - If no eligible port, s_axis_tready=0 and the FSM stalls with no state change.
  - PROC:
    - s_axis_tready = load.
    - All beats carry the latched sel in the tdest MSBs; changes to dest_enable are ignored.
    - No credit change.
    - A handshake with tlast returns the FSM to IDLE.
- Credit arithmetic:
  - If a return and a decrement hit the same port in the same cycle, the count is unchanged and this is not an overflow.
  - A return to a port at SLOT_COUNT with no same-cycle decrement saturates the count and pulses credit_overflow high for 1 cycle.
  - A return with credit_ret_dest ≥ M_COUNT is ignored and pulses credit_overflow.
- credit_count is driven from the registers and does not include the current cycle's update.
- Eligibility uses pre-update credit, so a credit returned in cycle t is usable in cycle t+1.

Test Plan:
- Reset, then 4 single-beat packets, all enabled, m_axis_tready=1 → tdest MSBs 0,1,2,3. credit_count each 7. First output appears 1 cycle after the first input handshake.
- 3-beat packet, with dest_enable toggled to 0 for the selected port during beat 2 → all 3 beats carry the same port, and credit is decremented once.
- Port 1 has credit 0, ports 0 and 2 enabled, pointer at 0 → selects 2. With all credits 0 → s_axis_tready stays 0. A return to port 3 → port 3 is selected the next cycle.
- Same-cycle first-beat handshake to port 2 and return to port 2 at credit 5 → credit stays 5, credit_overflow=0.
- Return to a port at 8 (SLOT_COUNT) → stays 8, credit_overflow pulses for exactly 1 cycle. Return with dest ≥ M_COUNT → pulse, no counts change.
- m_axis_tready random at 30% during 20 packets of 1–6 beats → output beat stream is identical to input, tlast is preserved, no bubble when tready=1, and total credits consumed = 20.
